// File: rtl/acc64_seq.sv
// acc64_seq -- sequential 64-bit accumulator built around one 32-bit adder.
//
// Each operand is added in two halves over two cycles (LO then HI). The carry
// out of the low half rides in the cy register into the high half. Operands
// stream in on a valid/ready handshake; i_last closes the stream. The result
// is then offered on o_valid/i_ready, and taking it clears the accumulator.
//
// Build option: define ACC_SIGNED_EN for two's-complement overflow detection.
// Without it, o_ovf reports unsigned carry-out. The sum bits are the same in
// both builds.
//
// Ports:
//   CLK      clock, rising edge
//   RSTb     asynchronous reset, active high
//   i_valid  operand valid         o_ready  operand can be accepted (IDLE)
//   i_data   64-bit operand        i_last   final operand of the stream
//   o_valid  result valid (DONE)   i_ready  downstream takes the result
//   o_sum    accumulator, visible at all times
//   o_cnt    operands accumulated, saturating at all-ones
//   o_ovf    sticky overflow flag, cleared on result handshake

module add32 (
  output logic [31:0] o_sum,
  output logic        o_c,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_c
);
  assign {o_c, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_c};
endmodule

module acc64_seq #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTb,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [63:0]      i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [63:0]      o_sum,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state;
  logic [63:0] acc;
  logic [63:0] op;
  logic        cy;
  logic        last;

  logic [31:0] add_a, add_b, add_s;
  logic        add_ci, add_co;
  logic        ovf_hit;

  // Adder operands: the high half is selected only in HI, so LO, IDLE and
  // DONE all see the low half with no carry-in.
  always_comb begin
    add_a  = acc[31:0];
    add_b  = op[31:0];
    add_ci = 1'b0;
    if (state == HI) begin
      add_a  = acc[63:32];
      add_b  = op[63:32];
      add_ci = cy;
    end
  end

  add32 u_add (
    .o_sum (add_s),
    .o_c   (add_co),
    .i_a   (add_a),
    .i_b   (add_b),
    .i_c   (add_ci)
  );

`ifdef ACC_SIGNED_EN
  // Signed overflow: both inputs share a sign and the result's sign differs.
  assign ovf_hit = (acc[63] == op[63]) && (add_s[31] != acc[63]);
`else
  assign ovf_hit = add_co;
`endif

  always_ff @(posedge CLK or posedge RSTb) begin
    if (RSTb) begin
      state <= IDLE;
      acc   <= '0;
      op    <= '0;
      cy    <= 1'b0;
      last  <= 1'b0;
      o_cnt <= '0;
      o_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            op    <= i_data;
            last  <= i_last;
            state <= LO;
          end
        end
        LO: begin
          acc[31:0] <= add_s;
          cy        <= add_co;
          state     <= HI;
        end
        HI: begin
          acc[63:32] <= add_s;
          if (o_cnt != '1) o_cnt <= o_cnt + CNT_W'(1);
          if (ovf_hit) o_ovf <= 1'b1;
          state <= last ? DONE : IDLE;
        end
        DONE: begin
          if (i_ready) begin
            acc   <= '0;
            o_cnt <= '0;
            o_ovf <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All three are pure decodes of registers, so none depend on inputs.
  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_sum   = acc;

endmodule

// File: tb/tb_acc64_seq.sv
// tb_acc64_seq -- self-checking bench for acc64_seq.
// A behavioural model tracks the running sum, count and overflow with plain
// wide arithmetic. A negedge compare process checks the DUT against it
// whenever no operand is in flight. Directed streams with literal results
// pin the model, and a randomized phase follows.
module tb_acc64_seq;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef ACC_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RSTb = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [63:0]   i_data = '0;
  logic          i_last = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [63:0]   o_sum;
  logic [CW-1:0] o_cnt;
  logic          o_ovf;

  acc64_seq #(.CNT_W(CW)) dut (
    .CLK(CLK), .RSTb(RSTb), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_sum(o_sum), .o_cnt(o_cnt), .o_ovf(o_ovf)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h want 0x%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_sum  = '0;
  int          m_cnt  = 0;
  bit          m_ovf  = 1'b0;
  int          busy   = 0;   // cycles until the accepted operand is settled
  bit          m_last = 1'b0;
  bit          pend   = 1'b0; // result waiting for downstream

  function automatic bit ovf_of(input logic [63:0] s, input logic [63:0] d);
    logic signed [64:0] rs;
    logic [64:0]        ru;
    rs = $signed({s[63], s}) + $signed({d[63], d});
    ru = {1'b0, s} + {1'b0, d};
    if (SGN) return rs[64] != rs[63];
    return ru[64];
  endfunction

  always @(posedge CLK or posedge RSTb) begin
    if (RSTb) begin
      m_sum <= '0; m_cnt <= 0; m_ovf <= 1'b0;
      busy <= 0; m_last <= 1'b0; pend <= 1'b0;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) pend <= m_last;
    end else if (pend) begin
      if (i_ready) begin
        m_sum <= '0; m_cnt <= 0; m_ovf <= 1'b0; pend <= 1'b0;
      end
    end else if (i_valid) begin
      m_sum  <= m_sum + i_data;
      m_cnt  <= (m_cnt == CMAX) ? m_cnt : m_cnt + 1;
      m_ovf  <= m_ovf | ovf_of(m_sum, i_data);
      busy   <= 2;
      m_last <= i_last;
    end
  end

  always @(negedge CLK) begin
    if (busy > 0) begin
      chk("ready_busy", o_ready, 0);
      chk("valid_busy", o_valid, 0);
    end else begin
      chk("m_ready", o_ready, !pend);
      chk("m_valid", o_valid, pend);
      chk("m_sum", o_sum, m_sum);
      chk("m_cnt", o_cnt, m_cnt);
      chk("m_ovf", o_ovf, m_ovf);
    end
  end

  // ---------------- directed helpers (called at a negedge) ----------------
  task automatic send_op(input logic [63:0] d, input bit last, input bit hold);
    i_valid = 1'b1; i_data = d; i_last = last;
    for (int k = 0; k < 40; k++) begin
      if (o_ready) break;
      @(negedge CLK);
    end
    chk("accept_ready", o_ready, 1);
    @(posedge CLK);
    @(negedge CLK);
    acc_cyc = cyc;
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic get_result(input logic [63:0] es, input int ec, input bit eo, output int lat);
    i_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) break;
      @(negedge CLK);
    end
    lat = cyc - acc_cyc;
    chk("res_valid", o_valid, 1);
    chk("res_sum", o_sum, es);
    chk("res_cnt", o_cnt, ec);
    chk("res_ovf", o_ovf, eo);
    @(negedge CLK);
    i_ready = 1'b0;
    chk("post_ready", o_ready, 1);
    chk("post_valid", o_valid, 0);
    chk("post_sum", o_sum, 0);
    chk("post_cnt", o_cnt, 0);
    chk("post_ovf", o_ovf, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1);
  end

  initial begin
    int lat, a1, a2;
    // Reset with i_valid asserted: nothing may be accepted.
    i_valid = 1'b1; i_data = 64'hDEAD; i_last = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_sum", o_sum, 0);
    chk("rst_cnt", o_cnt, 0);
    chk("rst_ovf", o_ovf, 0);
    i_valid = 1'b0;
    RSTb = 1'b0;
    @(negedge CLK);

    // Cross-word carry and latency.
    send_op(64'h0000_0000_FFFF_FFFF, 0, 0);
    send_op(64'h0000_0000_0000_0001, 1, 0);
    get_result(64'h0000_0001_0000_0000, 2, 0, lat);
    chk("latency", lat, 2);

    // All-ones plus one: unsigned wrap, signed -1 + 1.
    send_op(64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    send_op(64'h1, 1, 0);
    get_result(64'h0, 2, SGN ? 1'b0 : 1'b1, lat);

    // Max positive plus one: signed overflow only.
    send_op(64'h7FFF_FFFF_FFFF_FFFF, 0, 0);
    send_op(64'h1, 1, 0);
    get_result(64'h8000_0000_0000_0000, 2, SGN ? 1'b1 : 1'b0, lat);

    // Backpressure with new data offered.
    send_op(64'h5, 0, 0);
    send_op(64'h6, 1, 0);
    i_ready = 1'b0; i_valid = 1'b1; i_data = 64'h99; i_last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (o_valid) break;
      @(negedge CLK);
    end
    for (int k = 0; k < 10; k++) begin
      chk("bp_ready", o_ready, 0);
      chk("bp_sum", o_sum, 64'hB);
      @(negedge CLK);
    end
    i_ready = 1'b1;
    @(negedge CLK);
    chk("bp_rel_ready", o_ready, 1);
    chk("bp_rel_sum", o_sum, 0);
    @(negedge CLK);
    chk("bp_accept", o_ready, 0);
    i_valid = 1'b0;
    acc_cyc = cyc;
    get_result(64'h99, 1, 0, lat);

    // Reset while the operand is in HI.
    send_op(64'h1234, 0, 0);
    @(negedge CLK);
    #2 RSTb = 1'b1;
    #1;
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_sum", o_sum, 0);
    chk("mid_rst_cnt", o_cnt, 0);
    chk("mid_rst_ovf", o_ovf, 0);
    @(negedge CLK);
    RSTb = 1'b0;
    @(negedge CLK);
    send_op(64'h5, 1, 0);
    get_result(64'h5, 1, 0, lat);

    // Single operand, then back-to-back with i_valid held.
    send_op(64'hABCD, 1, 0);
    get_result(64'hABCD, 1, 0, lat);
    send_op(64'h1, 0, 1);
    a1 = acc_cyc;
    send_op(64'h2, 1, 0);
    a2 = acc_cyc;
    chk("b2b_spacing", a2 - a1, 3);
    get_result(64'h3, 2, 0, lat);

    // Count saturation leaves the sum intact.
    for (int k = 1; k <= 9; k++) send_op(64'(k), k == 9, 0);
    get_result(64'd45, CMAX, 0, lat);

    // Randomized phase: the compare process does the checking.
    for (int n = 0; n < 3000; n++) begin
      RSTb = 1'b0;
      i_valid = ($urandom % 4) != 0;
      case ($urandom % 4)
        0: i_data = {$urandom, $urandom};
        1: i_data = 64'hFFFF_FFFF_FFFF_FFFF;
        2: i_data = 64'h7FFF_FFFF_FFFF_FFFF;
        default: i_data = 64'($urandom % 16);
      endcase
      i_last  = ($urandom % 6) == 0;
      i_ready = ($urandom % 3) != 0;
      if ($urandom % 400 == 0) #2 RSTb = 1'b1;
      @(negedge CLK);
    end
    RSTb = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    repeat (10) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc64_seq.md
# acc64_seq

Sequential 64-bit accumulator that drives the team's combinational 32-bit adder (`add32`, ports `o_sum`/`o_c`/`i_a`/`i_b`/`i_c`) as its single arithmetic resource. Each 64-bit operand is split into two 32-bit halves and added over two cycles, with the carry rippling through an internal register. A valid/ready handshake accepts a stream of operands terminated by `i_last`, and the same handshake presents the final sum downstream.

## Interface
- `CNT_W`, default 16: width of the operand counter `o_cnt`.
- `CLK` input 1: clock; all state updates on the rising edge.
- `RSTb` input 1: asynchronous reset, active-high.
- `i_valid` input 1: upstream operand valid.
- `o_ready` output 1: block can accept an operand.
- `i_data` input 64: operand.
- `i_last` input 1: final operand of the stream; sampled with `i_data`.
- `o_valid` output 1: result valid.
- `i_ready` input 1: downstream accepts the result.
- `o_sum` output 64: accumulated sum.
- `o_cnt` output `CNT_W`: number of operands accumulated. Saturates at all-ones.
- `o_ovf` output 1: sticky overflow flag.

## Operation
- Contains one `add32` instance. Its inputs are muxed by state:
  - LO: `i_a` = `acc[31:0]`, `i_b` = `op[31:0]`, `i_c` = 0.
  - HI: `i_a` = `acc[63:32]`, `i_b` = `op[63:32]`, `i_c` = `cy`.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - `o_ready` = 1.
  - On `i_valid` & `o_ready`: `op` <= `i_data`, `last` <= `i_last`, go to LO.
- LO:
  - `acc[31:0]` <= `o_sum`, `cy` <= `o_c`.
  - Go to HI.
- HI:
  - `acc[63:32]` <= `o_sum`.
  - `o_cnt` increments unless already at all-ones.
  - `o_ovf` is set if an overflow occurred (see Configuration). It is never cleared here.
  - If `last` is set, go to DONE; otherwise go to IDLE.
- DONE:
  - `o_valid` = 1 and `o_sum` = `acc`.
  - On `i_ready`, in the same edge: `acc`, `o_cnt`, and `o_ovf` clear to 0, then go to IDLE.
- `o_ready` is 0 in LO, HI, and DONE. `i_data` is ignored outside IDLE.
- Arithmetic is modulo 2^64; a wrap-around is reported only through `o_ovf`.
- `o_sum` always reflects `acc`, including while accumulation is in progress.

## Timing
- Reset values: state IDLE, `acc` = 0, `op` = 0, `cy` = 0, `last` = 0.
- Reset output values: `o_ready` = 1, `o_valid` = 0, `o_sum` = 0, `o_cnt` = 0, `o_ovf` = 0.
- Throughput: one operand every 3 cycles (accept edge, LO edge, HI edge).
- Latency: if the last operand is accepted at edge E, `o_valid` rises after edge E+2. The result handshake can complete at E+3 at the earliest.
- `o_valid` holds, with `o_sum` stable, until `i_ready`. The block does not accept new operands while `o_valid` is high.
- A `i_last` = 1 on the first operand is legal: the result is that operand, with `o_cnt` = 1.
- `o_cnt` saturation does not affect the sum.
- Assertion of `RSTb` in any state, including mid-LO/HI, returns everything to the reset values immediately. A partially added operand is discarded.
- `i_valid` high during reset has no effect. The first possible accept is the first rising edge after `RSTb` deasserts.

## Configuration
- Macro `ACC_SIGNED_EN`.
- Defined: operands and accumulator are two's complement. In HI, `o_ovf` sets when `acc[63]` == `op[63]` and the new `acc[63]` differs.
- Undefined: operands are unsigned. In HI, `o_ovf` sets when the `add32` `o_c` is 1.
- Only overflow detection changes; the sum bits are identical in both builds.

## Test plan
- Unsigned build, cross-word carry: after reset, send 0x0000_0000_FFFF_FFFF then 0x0000_0000_0000_0001 (`i_last`) -> `o_sum` = 0x0000_0001_0000_0000, `o_cnt` = 2, `o_ovf` = 0, `o_valid` high 2 edges after the last accept.
- Unsigned wrap-around: send 0xFFFF_FFFF_FFFF_FFFF then 0x1 (last) -> `o_sum` = 0, `o_ovf` = 1. After the `i_ready` handshake, all outputs = 0 and `o_ready` = 1.
- Signed build (`ACC_SIGNED_EN`): send 0x7FFF_FFFF_FFFF_FFFF then 0x1 (last) -> `o_sum` = 0x8000_0000_0000_0000, `o_ovf` = 1. Send 0xFFFF_FFFF_FFFF_FFFF then 0x1 (last) -> `o_sum` = 0, `o_ovf` = 0.
- Backpressure: hold `i_ready` = 0 for 10 cycles in DONE while `i_valid` = 1 with new data -> `o_sum` stays stable, `o_ready` = 0, no operand is accepted. Release `i_ready` -> accumulation restarts from 0.
- Reset mid-operation: accept 0x1234, assert `RSTb` while in HI -> all outputs return to reset values. Then send 0x5 (last) -> `o_sum` = 0x5, `o_cnt` = 1.
- Single-operand and back-to-back streams: 0xABCD (last), then 0x1 and 0x2 (last) with `i_valid` held high -> results 0xABCD (cnt 1), then 0x3 (cnt 2). Each accept is spaced 3 cycles apart.
